// File: rtl/fifo_readout_ctrl.sv
// Drains the 34-bit timestamp FIFO into framed 7-byte packets (header, 34-bit word, XOR check) on a byte stream.
// One-cycle read pop at capture; TX_DATA/TX_VALID are held while TX_READY is low.
module fifo_readout_ctrl #(
    parameter logic [7:0] HDR_NORM = 8'hA5,
    parameter logic [7:0] HDR_OVF  = 8'hA6,
    parameter int         CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             EN,
    input  logic [33:0]      FIFO_Q,
    input  logic             FIFO_EMPTY,
    input  logic             FIFO_FULL,
    output logic             FIFO_RD,
    output logic [7:0]       TX_DATA,
    output logic             TX_VALID,
    input  logic             TX_READY,
    output logic             BUSY,
    output logic             OVF,
    output logic [CNT_W-1:0] PKT_CNT
);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [33:0]        r_word;
    logic [7:0]         r_hdr;
    logic [7:0]         r_chk;
    logic [2:0]         r_idx;

    logic               w_capture;
    logic               w_xfer;
    logic               w_last;
    logic [7:0]         w_hdr;
    logic [7:0]         w_chk;
    logic               w_rd_nxt;
    logic [7:0]         w_data_nxt;
    logic               w_valid_nxt;
    logic               w_busy_nxt;
    logic               w_ovf_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [2:0]         w_idx_nxt;

    function automatic logic [7:0] f_byte(input logic [2:0] idx, input logic [33:0] w,
                                          input logic [7:0] hdr, input logic [7:0] chk);
        case (idx)
            3'd0:    f_byte = hdr;
            3'd1:    f_byte = {6'b0, w[33:32]};
            3'd2:    f_byte = w[31:24];
            3'd3:    f_byte = w[23:16];
            3'd4:    f_byte = w[15:8];
            3'd5:    f_byte = w[7:0];
            default: f_byte = chk;
        endcase
    endfunction

    assign w_capture = (r_state == S_IDLE) && EN && !FIFO_EMPTY;
    assign w_xfer    = TX_VALID && TX_READY;
    assign w_last    = (r_idx == 3'd6);
    // Header sees overflow up to and including the capture edge itself.
    assign w_hdr     = (OVF || FIFO_FULL) ? HDR_OVF : HDR_NORM;
    assign w_chk     = w_hdr ^ {6'b0, FIFO_Q[33:32]} ^ FIFO_Q[31:24] ^ FIFO_Q[23:16]
                       ^ FIFO_Q[15:8] ^ FIFO_Q[7:0];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_capture) w_state_nxt = S_SEND;
            S_SEND:  if (w_xfer && w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_nxt    = 1'b0;
        w_data_nxt  = TX_DATA;
        w_valid_nxt = TX_VALID;
        w_busy_nxt  = BUSY;
        w_ovf_nxt   = OVF || FIFO_FULL;
        w_cnt_nxt   = PKT_CNT;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_rd_nxt    = 1'b1;
                    w_data_nxt  = w_hdr;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_ovf_nxt   = FIFO_FULL;
                    w_idx_nxt   = 3'd0;
                end
            end
            S_SEND: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_cnt_nxt   = PKT_CNT + CNT_W'(1);
                    end else begin
                        w_idx_nxt  = r_idx + 3'd1;
                        w_data_nxt = f_byte(r_idx + 3'd1, r_word, r_hdr, r_chk);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            FIFO_RD  <= 1'b0;
            TX_DATA  <= 8'h00;
            TX_VALID <= 1'b0;
            BUSY     <= 1'b0;
            OVF      <= 1'b0;
            PKT_CNT  <= '0;
            r_idx    <= 3'd0;
            r_word   <= '0;
            r_hdr    <= 8'h00;
            r_chk    <= 8'h00;
        end else begin
            FIFO_RD  <= w_rd_nxt;
            TX_DATA  <= w_data_nxt;
            TX_VALID <= w_valid_nxt;
            BUSY     <= w_busy_nxt;
            OVF      <= w_ovf_nxt;
            PKT_CNT  <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            if (w_capture) begin
                r_word <= FIFO_Q;
                r_hdr  <= w_hdr;
                r_chk  <= w_chk;
            end
        end
    end

endmodule
